inst_mem_loader: RTL
====================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256, instruction words stored; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter BIG_ENDIAN, default 1; when 1 the first byte received is the MSB of each word, when 0 it is the LSB.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- load_start  in  1  single-cycle request to begin a load
- load_len  in  ADDR_W+1  words to load, sampled with load_start
- in_valid  in  1  in_data carries a byte
- in_data  in  8  program byte
- in_ready  out  1  loader accepts a byte this cycle
- fetch_addr  in  32  byte address from core PC
- instr  out  DATA_W  instruction at fetch_addr
- core_run  out  1  core enable; core holds PC while low
- load_done  out  1  one-cycle pulse, load complete
- load_err  out  1  sticky error, load_len > DEPTH

Function
REQ-005 SHALL implement states IDLE, LOAD, DONE, RUN.
REQ-006 Transitions:
- IDLE->LOAD on load_start with 0 < load_len <= DEPTH.
- IDLE->DONE on load_start with load_len == 0.
- IDLE stays IDLE on load_start with load_len > DEPTH, and load_err is set to 1.
- LOAD->DONE when the last word is written.
- DONE->RUN unconditionally.
- RUN->LOAD or RUN->DONE on load_start, with the same length rules as IDLE.
REQ-007 On entry to LOAD, the write pointer and byte counter SHALL clear to 0.
REQ-008 A byte SHALL be accepted only at a rising edge with in_valid && in_ready; in_ready = 1 only in LOAD.
REQ-009 Each group of DATA_W/8 accepted bytes SHALL be assembled per BIG_ENDIAN and written to mem[wr_ptr] on the edge accepting the final byte; wr_ptr then increments.
REQ-010 in_valid gaps SHALL stall assembly without losing partial bytes.
REQ-011 load_start during LOAD or DONE SHALL be ignored.
REQ-012 load_done SHALL be 1 exactly during DONE.
REQ-013 core_run SHALL be 1 only in RUN; it falls on the edge that leaves RUN.
REQ-014 Latency with in_valid held high: N*DATA_W/8 cycles in LOAD, 1 cycle in DONE, then core_run=1.
REQ-015 instr SHALL be a combinational read of mem[fetch_addr[ADDR_W+1:2]] (word-aligned; fetch_addr[1:0] ignored).
REQ-016 instr SHALL be 0 (NOP) when:
- fetch_addr[31:ADDR_W+2] != 0, or
- the word index >= the length of the last completed load, or
- the state is not RUN.
REQ-017 Words beyond the loaded length SHALL read 0 even if written by an earlier, longer load.
REQ-018 load_err SHALL clear only on rst or on an accepted valid load_start.

Reset
REQ-019 On rst:
- state = IDLE
- in_ready = 0, instr = 0, core_run = 0, load_done = 0, load_err = 0
- wr_ptr, byte counter and loaded length = 0
- memory contents are not cleared
REQ-020 rst asserted mid-LOAD SHALL abandon the partial word; a later read returns 0 because the loaded length is 0.

Structure
REQ-021 State encoding and the byte-lane constant BYTES = DATA_W/8 SHALL live in shared package proc_pkg.
REQ-022 SHALL contain one sub-module, word_assembler: byte shift register, byte counter, word_ready strobe.
REQ-023 Memory SHALL be a plain register array inferable as distributed RAM.

Verification
REQ-024 Defaults; load_start, load_len=3; bytes 00 11 22 33 44 55 66 77 88 99 AA BB with in_valid held -> load_done pulse at cycle 13, core_run=1 at cycle 14, fetch_addr 0/4/8 gives 00112233/44556677/8899AABB.
REQ-025 Same stream with BIG_ENDIAN=0 -> fetch_addr 0 gives 33221100; fetch_addr 12 gives 0.
REQ-026 in_valid toggled every other cycle across 2 words -> same data as with no gaps; load_done 16 cycles after load_start.
REQ-027 load_len=257 at DEPTH=256 -> load_err=1, state stays IDLE, in_ready=0; next load_start with load_len=1 clears load_err.
REQ-028 rst after 6 of 8 bytes, then reload with 1 word DEADBEEF -> fetch_addr 0 gives DEADBEEF, fetch_addr 4 gives 0.
REQ-029 In RUN, load_start with load_len=0 -> core_run=0 for one cycle, load_done=1, then RUN; every fetch returns 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte-lane helpers used by the loader and its word assembler.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } ldr_state_e;

    localparam int BYTE_W         = 8;
    localparam int DEFAULT_DATA_W = 32;
    // Byte lanes per instruction word at the default word width.
    localparam int BYTES          = DEFAULT_DATA_W / BYTE_W;

    // Byte lanes for an arbitrary word width (width must be a multiple of 8).
    function automatic int lanes_of(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Collects a stream of bytes into DATA_W-bit words. The word is presented
// combinationally together with word_ready on the cycle the final byte is
// accepted, so the caller can write it on that same clock edge.
module word_assembler
    import proc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_ready,
    output logic [DATA_W-1:0] word_data
);

    localparam int NB    = lanes_of(DATA_W);
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lane_q [NB];
    logic [7:0]       lane_d [NB];
    logic [CNT_W-1:0] lane_sel;
    logic             last_byte;

    // First byte lands in the top lane for big-endian, bottom lane otherwise.
    assign lane_sel  = BIG_ENDIAN ? (CNT_W'(NB - 1) - cnt_q) : cnt_q;
    assign last_byte = (cnt_q == CNT_W'(NB - 1));
    assign word_ready = byte_valid && !clear && last_byte;

    // Next-state for the byte counter and the lane holding registers.
    always_comb begin
        cnt_d  = cnt_q;
        lane_d = lane_q;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            lane_d[lane_sel] = byte_data;
            cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Byte counter; a gap in byte_valid simply holds the count and lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Lane data needs no reset: it is only consumed behind word_ready.
    always_ff @(posedge clk) begin
        lane_q <= lane_d;
    end

    // Final byte bypasses the lane register so the word is complete on time.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign word_data[gi*8 +: 8] =
                (byte_valid && (lane_sel == CNT_W'(gi))) ? byte_data : lane_q[gi];
        end
    endgenerate

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader: receives a program as a byte stream,
// packs it into words, then releases the core and serves instruction fetches.
module inst_mem_loader
    import proc_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  DEPTH      = 256,
    parameter bit  BIG_ENDIAN = 1'b1,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [31:0]       fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              core_run,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   tgt_len_q, tgt_len_d;
    logic [ADDR_W:0]   loaded_len_q, loaded_len_d;
    logic              load_err_q, load_err_d;
    logic              load_done_q, load_done_d;
    logic              core_run_q, core_run_d;
    logic              in_ready_q, in_ready_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              asm_clear;
    logic              word_ready;
    logic [DATA_W-1:0] word_data;

    assign accept = in_valid && in_ready_q;

    word_assembler #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (accept),
        .byte_data  (in_data),
        .word_ready (word_ready),
        .word_data  (word_data)
    );

    // Loader FSM next-state: start requests honoured only from IDLE or RUN.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        tgt_len_d    = tgt_len_q;
        loaded_len_d = loaded_len_q;
        load_err_d   = load_err_q;
        asm_clear    = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    if (load_len > DEPTH_L) begin
                        load_err_d = 1'b1;
                    end else begin
                        load_err_d = 1'b0;
                        tgt_len_d  = load_len;
                        if (load_len == '0) begin
                            state_d      = ST_DONE;
                            loaded_len_d = '0;
                        end else begin
                            state_d   = ST_LOAD;
                            wr_ptr_d  = '0;
                            asm_clear = 1'b1;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (word_ready) begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (({1'b0, wr_ptr_q} + (ADDR_W + 1)'(1)) == tgt_len_q) begin
                        state_d      = ST_DONE;
                        loaded_len_d = tgt_len_q;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        load_done_d = (state_d == ST_DONE);
        core_run_d  = (state_d == ST_RUN);
        in_ready_d  = (state_d == ST_LOAD);
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            tgt_len_q    <= '0;
            loaded_len_q <= '0;
            load_err_q   <= 1'b0;
            load_done_q  <= 1'b0;
            core_run_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            tgt_len_q    <= tgt_len_d;
            loaded_len_q <= loaded_len_d;
            load_err_q   <= load_err_d;
            load_done_q  <= load_done_d;
            core_run_q   <= core_run_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Program store: written once per assembled word, never cleared.
    always_ff @(posedge clk) begin
        if (word_ready) begin
            mem[wr_ptr_q] <= word_data;
        end
    end

    // Fetch port: word-aligned asynchronous read, NOP outside the loaded image.
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_ok;
    logic              unused_fetch_lsb;

    assign fetch_idx        = fetch_addr[ADDR_W+1:2];
    assign unused_fetch_lsb = ^fetch_addr[1:0];
    assign fetch_ok = (state_q == ST_RUN)
                   && (fetch_addr[31:ADDR_W+2] == '0)
                   && ({1'b0, fetch_idx} < loaded_len_q);
    assign instr = fetch_ok ? mem[fetch_idx] : '0;

    assign in_ready  = in_ready_q;
    assign core_run  = core_run_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule
